// File: rtl/mul_issue_ctrl_pkg.sv
// rtl/mul_issue_ctrl_pkg.sv - shared constants and helpers for the multiplier issue controller
package mul_issue_ctrl_pkg;

    localparam int MUL_NUM_RS    = 3;
    localparam int MUL_TAG_W     = 4;
    localparam int MUL_DATA_W    = 32;
    // Must equal the stage count of the multiplier being scheduled.
    localparam int MUL_LATENCY   = 6;
    localparam int MUL_BUF_DEPTH = 8;

    function automatic int rr_next(input int k, input int n);
        return (k + 1 >= n) ? 0 : k + 1;
    endfunction

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// rtl/mul_issue_ctrl_if.sv - station, multiplier and CDB handshake bundle
interface mul_issue_ctrl_if #(
    parameter int NUM_RS = mul_issue_ctrl_pkg::MUL_NUM_RS,
    parameter int TAG_W  = mul_issue_ctrl_pkg::MUL_TAG_W
);
    logic [NUM_RS-1:0]       rs_req;
    logic [NUM_RS*TAG_W-1:0] rs_tag;
    logic [NUM_RS*32-1:0]    rs_a;
    logic [NUM_RS*32-1:0]    rs_b;
    logic [NUM_RS-1:0]       rs_grant;
    logic                    mul_EN;
    logic [31:0]             mul_dataIn1;
    logic [31:0]             mul_dataIn2;
    logic [31:0]             mul_result;
    logic                    cdb_require;
    logic                    cdb_requireAC;
    logic [TAG_W-1:0]        cdb_tag;
    logic [31:0]             cdb_data;
    logic                    available;

    modport master (
        output rs_req, rs_tag, rs_a, rs_b, mul_result, cdb_requireAC,
        input  rs_grant, mul_EN, mul_dataIn1, mul_dataIn2,
               cdb_require, cdb_tag, cdb_data, available
    );

    modport slave (
        input  rs_req, rs_tag, rs_a, rs_b, mul_result, cdb_requireAC,
        output rs_grant, mul_EN, mul_dataIn1, mul_dataIn2,
               cdb_require, cdb_tag, cdb_data, available
    );
endinterface

// File: rtl/mul_result_fifo.sv
// rtl/mul_result_fifo.sv - circular result buffer holding {tag, product} awaiting the CDB
module mul_result_fifo #(
    parameter int  DEPTH = 8,
    parameter int  WIDTH = 36,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o
);
    import mul_issue_ctrl_pkg::*;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;
    assign do_pop      = pop_i && !empty_o;
    assign head_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push_i, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (rst_i)
        count_q <= CNT_W'(DEPTH));
    a_no_overflow: assert property (@(posedge clk) disable iff (rst_i)
        !(push_i && !do_pop && count_q == CNT_W'(DEPTH)));

endmodule

// File: rtl/mul_issue_ctrl.sv
// rtl/mul_issue_ctrl.sv - round-robin, credit-gated issue to a fixed-latency multiplier with CDB result buffer
module mul_issue_ctrl #(
    parameter int NUM_RS    = mul_issue_ctrl_pkg::MUL_NUM_RS,
    parameter int TAG_W     = mul_issue_ctrl_pkg::MUL_TAG_W,
    parameter int LATENCY   = mul_issue_ctrl_pkg::MUL_LATENCY,
    parameter int BUF_DEPTH = mul_issue_ctrl_pkg::MUL_BUF_DEPTH
) (
    input logic           clk,
    input logic           RST,
    mul_issue_ctrl_if.slave bus
);
    import mul_issue_ctrl_pkg::*;

    localparam int PTR_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  win_idx;
    logic              found;
    logic              can_issue;
    logic [CNT_W-1:0]  inflight_cnt_q, inflight_cnt_d;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    credit_used;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [TAG_W-1:0]  tag_q [LATENCY];
    logic              push, pop, fifo_empty;
    logic [TAG_W+31:0] head;

    logic [31:0]      a_arr [NUM_RS];
    logic [31:0]      b_arr [NUM_RS];
    logic [TAG_W-1:0] t_arr [NUM_RS];

    for (genvar i = 0; i < NUM_RS; i++) begin : g_unpack
        assign a_arr[i] = bus.rs_a[i*32 +: 32];
        assign b_arr[i] = bus.rs_b[i*32 +: 32];
        assign t_arr[i] = bus.rs_tag[i*TAG_W +: TAG_W];
    end

    // Products already in the pipe each hold a reserved FIFO slot, so a stalled CDB never drops one.
    assign credit_used = {1'b0, inflight_cnt_q} + {1'b0, fifo_count};
    assign can_issue   = credit_used < (CNT_W+1)'(BUF_DEPTH);

    always_comb begin
        logic [PTR_W:0] cand;
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int off = 0; off < NUM_RS; off++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(off);
            if (cand >= (PTR_W+1)'(NUM_RS)) begin
                cand = cand - (PTR_W+1)'(NUM_RS);
            end
            if (can_issue && !found && bus.rs_req[cand[PTR_W-1:0]]) begin
                found   = 1'b1;
                win_idx = cand[PTR_W-1:0];
            end
        end
    end

    assign bus.rs_grant    = found ? (NUM_RS'(1) << win_idx) : '0;
    assign bus.mul_EN      = found;
    assign bus.mul_dataIn1 = found ? a_arr[win_idx] : '0;
    assign bus.mul_dataIn2 = found ? b_arr[win_idx] : '0;
    assign bus.available   = can_issue;

    assign push = vld_q[LATENCY-1];
    assign pop  = bus.cdb_require && bus.cdb_requireAC;

    always_comb begin
        rr_ptr_d       = found ? PTR_W'(rr_next(int'(win_idx), NUM_RS)) : rr_ptr_q;
        vld_d          = {vld_q[LATENCY-2:0], found};
        inflight_cnt_d = inflight_cnt_q;
        case ({found, push})
            2'b10:   inflight_cnt_d = inflight_cnt_q + 1'b1;
            2'b01:   inflight_cnt_d = inflight_cnt_q - 1'b1;
            default: inflight_cnt_d = inflight_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            rr_ptr_q       <= '0;
            inflight_cnt_q <= '0;
            vld_q          <= '0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            inflight_cnt_q <= inflight_cnt_d;
            vld_q          <= vld_d;
        end
    end

    // Tags need no reset: only the valid bits decide whether a stage is pushed.
    always_ff @(posedge clk) begin
        tag_q[0] <= t_arr[win_idx];
        for (int i = 1; i < LATENCY; i++) begin
            tag_q[i] <= tag_q[i-1];
        end
    end

    mul_result_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (TAG_W + 32)
    ) u_fifo (
        .clk         (clk),
        .rst_i       (RST),
        .push_i      (push),
        .push_data_i ({tag_q[LATENCY-1], bus.mul_result}),
        .pop_i       (pop),
        .head_data_o (head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

    assign bus.cdb_require = !fifo_empty;
    assign bus.cdb_tag     = head[TAG_W+31:32];
    assign bus.cdb_data    = head[31:0];

endmodule
